// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 4-digit 7-segment scan controller
// Contents: scan state enum, arbiter priority enum, blank/off constants, hex glyph table,
// and the state-to-digit mapping helper.
package seg_pkg;
    typedef enum logic [1:0] {LEFT, MIDLEFT, MIDRIGHT, RIGHT} scan_t;
    typedef enum logic {PRIO_A, PRIO_B} prio_t;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF = 4'b1111;
    // Active-low {g,f,e,d,c,b,a} glyphs, entry F first so HEX_GLYPH[v] selects value v
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
    // LEFT drives digit 3 down to RIGHT driving digit 0
    function automatic logic [1:0] scan_digit(scan_t s);
        return 2'd3 - 2'(s);
    endfunction
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-low 7-segment decoder
// Ports: val (4-bit hex value), vld (digit valid; low blanks the digit), seg (active-low {g,f,e,d,c,b,a}).
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] val,
    input  logic       vld,
    output logic [6:0] seg
);
    assign seg = vld ? HEX_GLYPH[val] : SEG_BLANK;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: two-requester digit buffer with round-robin arbiter and 4-digit 7-segment scanner
// Ports: clk, clr (sync active-high reset); requester A/B: *_valid, *_idx (3 = leftmost), *_val, *_ready;
// seg (active-low {g,f,e,d,c,b,a}), an (active-low anodes, an[3] = leftmost).
// Optional macro SEG_BLANK_LZ_EN enables leading-zero blanking of digits 3..1.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 131072,
    parameter int CNT_W   = 17
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       a_valid,
    input  logic [1:0] a_idx,
    input  logic [3:0] a_val,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [1:0] b_idx,
    input  logic [3:0] b_val,
    output logic       b_ready,
    output logic [6:0] seg,
    output logic [3:0] an
);
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [3:0]       dig [4];
    logic [3:0]       vld;
    logic [3:0]       show;
    prio_t            prio;
    scan_t            state, state_d;
    logic [6:0]       seg_d, glyph;
    logic [3:0]       an_d;
    logic [1:0]       sel;

    assign a_ready = !clr & a_valid & (!b_valid | prio == PRIO_A);
    assign b_ready = !clr & b_valid & (!a_valid | prio == PRIO_B);
    assign tick = cnt == CNT_W'(CLK_DIV - 1);
    assign sel = scan_digit(state);

`ifdef SEG_BLANK_LZ_EN
    logic [3:0] z;
    for (genvar k = 0; k < 4; k++) begin : g_zero
        assign z[k] = !vld[k] | dig[k] == 4'd0;
    end
    // A valid zero is blanked while everything above it is also zero or invalid
    assign show = {vld[3] & ~z[3], vld[2] & ~&z[3:2], vld[1] & ~&z[3:1], vld[0]};
`else
    assign show = vld;
`endif

    hex_to_seg u_dec (.val(dig[sel]), .vld(show[sel]), .seg(glyph));

    always_comb begin
        state_d = state;
        seg_d = seg;
        an_d = an;
        if (tick) begin
            state_d = scan_t'(state + 2'd1);
            seg_d = glyph;
            an_d = ~(4'b0001 << sel);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
            state <= LEFT;
            seg <= SEG_BLANK;
            an <= AN_OFF;
            prio <= PRIO_A;
            vld <= '0;
            dig <= '{default: '0};
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            state <= state_d;
            seg <= seg_d;
            an <= an_d;
            if (a_ready) begin
                dig[a_idx] <= a_val;
                vld[a_idx] <= 1'b1;
                prio <= PRIO_B;
            end else if (b_ready) begin
                dig[b_idx] <= b_val;
                vld[b_idx] <= 1'b1;
                prio <= PRIO_A;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus random bench for seg_scan_ctrl against a cycle-count reference model
module tb_seg_scan_ctrl;
    localparam int DIV = 4;
    logic clk = 0, clr = 1, a_valid = 0, b_valid = 0;
    logic [1:0] a_idx = 0, b_idx = 0;
    logic [3:0] a_val = 0, b_val = 0;
    logic a_ready, b_ready;
    logic [6:0] seg;
    logic [3:0] an;
    int errors = 0, checks = 0;
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int md [4];
    bit mv [4];
    bit prio_b;
    int n;
    logic [6:0] eseg;
    logic [3:0] ean;

    seg_scan_ctrl #(.CLK_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .clr(clr),
        .a_valid(a_valid), .a_idx(a_idx), .a_val(a_val), .a_ready(a_ready),
        .b_valid(b_valid), .b_idx(b_idx), .b_val(b_val), .b_ready(b_ready),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] model_glyph(int k);
        if (!mv[k]) return 7'h7F;
`ifdef SEG_BLANK_LZ_EN
        if (k > 0 && md[k] == 0) begin
            bit lead = 1;
            for (int j = k + 1; j < 4; j++) if (mv[j] && md[j] != 0) lead = 0;
            if (lead) return 7'h7F;
        end
`endif
        return glyph_tab[md[k]];
    endfunction

    task automatic check(string tag, logic [6:0] got, logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h n=%0d", tag, got, exp, n);
        end
    endtask

    task automatic cyc();
        bit ga, gb;
        #1;
        if (clr) begin
            ga = 0;
            gb = 0;
        end else if (a_valid && b_valid) begin
            ga = !prio_b;
            gb = prio_b;
        end else begin
            ga = a_valid;
            gb = b_valid;
        end
        check("a_ready", 7'(a_ready), 7'(ga));
        check("b_ready", 7'(b_ready), 7'(gb));
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                md[i] = 0;
                mv[i] = 0;
            end
            prio_b = 0;
            n = 0;
            eseg = 7'h7F;
            ean = 4'hF;
        end else begin
            if (n % DIV == DIV - 1) begin
                int d = 3 - (n / DIV) % 4;
                eseg = model_glyph(d);
                ean = ~(4'b0001 << d);
            end
            n++;
            if (ga) begin
                md[a_idx] = int'(a_val);
                mv[a_idx] = 1;
                prio_b = 1;
            end
            if (gb) begin
                md[b_idx] = int'(b_val);
                mv[b_idx] = 1;
                prio_b = 0;
            end
        end
        #1;
        check("seg", seg, eseg);
        check("an", 7'(an), 7'(ean));
    endtask

    initial begin
        clr = 1;
        cyc();
        cyc();
        clr = 0;
        repeat (24) cyc();
        a_valid = 1; a_idx = 3; a_val = 4'h1;
        cyc();
        a_idx = 0; a_val = 4'hF;
        cyc();
        a_valid = 0;
        repeat (16) cyc();
        b_valid = 1; b_idx = 1; b_val = 4'h9;
        cyc();
        b_valid = 0;
        a_valid = 1; b_valid = 1; a_idx = 2; b_idx = 2;
        a_val = 4'h3; b_val = 4'h5;
        cyc();
        a_val = 4'h4; b_val = 4'h6;
        cyc();
        a_val = 4'h7; b_val = 4'h8;
        cyc();
        a_valid = 0; b_valid = 0;
        repeat (16) cyc();
        for (int i = 0; i < 16 && n % 16 != 3; i++) cyc();
        a_valid = 1; a_idx = 3; a_val = 4'hC;
        cyc();
        a_valid = 0;
        repeat (20) cyc();
        for (int i = 0; i < 16 && n % 16 != 9; i++) cyc();
        clr = 1;
        cyc();
        clr = 0;
        a_valid = 1; b_valid = 1; a_idx = 0; b_idx = 1; a_val = 4'hA; b_val = 4'hB;
        cyc();
        a_valid = 0; b_valid = 0;
        repeat (8) cyc();
        clr = 1;
        cyc();
        clr = 0;
        a_valid = 1; a_val = 4'h0;
        for (int i = 0; i < 4; i++) begin
            a_idx = 2'(i);
            cyc();
        end
        a_valid = 0;
        repeat (16) cyc();
        a_valid = 1; a_idx = 2; a_val = 4'h2;
        cyc();
        a_idx = 0; a_val = 4'h5;
        cyc();
        a_valid = 0;
        repeat (16) cyc();
        repeat (400) begin
            clr = $urandom_range(0, 49) == 0;
            a_valid = 1'($urandom);
            b_valid = 1'($urandom);
            a_idx = 2'($urandom);
            b_idx = 2'($urandom);
            a_val = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
            b_val = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
            cyc();
        end
        clr = 0; a_valid = 0; b_valid = 0;
        repeat (16) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Scan controller and shared-access front end for the 4-digit 7-segment display on the board.
- Two requesters (A: main logic, B: status/debug) write hex digits into a 4-entry digit buffer through a round-robin arbiter.
- An internal prescaler sets the scan rate; the scan FSM drives one digit per scan period with a registered seg/an.
- Replaces free-running, hardcoded-letter scanners; sits directly on the board seg/an pins.

Parameters:
- CLK_DIV, 131072: clk cycles per digit scan period (2.62 ms at 50 MHz). Legal values ≥ 2.
- CNT_W, 17: prescaler width. Must satisfy 2^CNT_W ≥ CLK_DIV.

Ports:
- clk  in  1  system clock
- clr  in  1  reset: synchronous, active-high
- a_valid  in  1  requester A write request
- a_idx  in  2  A target digit (3 = leftmost, 0 = rightmost)
- a_val  in  4  A hex value
- a_ready  out  1  A write accepted this cycle
- b_valid, b_idx, b_val, b_ready: same widths and meanings for requester B
- seg  out  7  segment cathodes, active-low, bit order {g,f,e,d,c,b,a}
- an  out  4  digit anodes, active-low, an[3] = leftmost

Behaviour:
- Reset (clr high at a clk edge):
  - seg=7'b1111111, an=4'b1111
  - scan state=LEFT, prescaler=0, priority pointer=A
  - all 4 digit values=0, all digit-valid bits=0
- Arbiter (combinational ready; at most one buffer write per cycle):
  - a_ready = a_valid & (!b_valid | prio==A); b_ready = b_valid & (!a_valid | prio==B).
  - Never both ready in the same cycle. ready is low whenever valid is low.
  - On a handshake, the buffer entry idx takes val and its valid bit sets at that clk edge.
  - After any grant, prio points to the non-granted requester. With no grant, prio holds.
  - Requests are ignored during clr; ready is forced low while clr is high.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (count == CLK_DIV-1).
- Scan FSM: states LEFT → MIDLEFT → MIDRIGHT → RIGHT → LEFT, advancing on tick only.
  - On tick in LEFT: an=0111, seg=decode(digit 3). MIDLEFT: an=1011, digit 2. MIDRIGHT: an=1101, digit 1. RIGHT: an=1110, digit 0.
  - decode: standard active-low hex glyphs 0-F. Any digit whose valid bit is 0 drives 7'b1111111.
  - seg/an change only on tick. First non-reset output appears CLK_DIV cycles after clr deasserts.
  - Full refresh period = 4*CLK_DIV cycles.
- Boundary cases:
  - A write to the digit currently displayed becomes visible at that digit's next scan slot, not immediately.
  - A write landing on the same edge as a tick for that digit: the tick uses the pre-write value.
  - Repeated writes to the same idx: last write wins.
  - clr mid-scan forces the reset values on the next edge, including while a tick is pending.

Optional Feature:
- Macro: SEG_BLANK_LZ_EN.
- Defined: leading-zero blanking.
  - Digit k (k = 3..1) is blanked if its value is 0 and every digit above it is either 0 or invalid.
  - Digit 0 is never blanked by this rule.
- Undefined: zeros are displayed whenever their valid bit is set.

Decomposition:
- Shared package seg_pkg:
  - scan state enum (LEFT, MIDLEFT, MIDRIGHT, RIGHT)
  - SEG_BLANK = 7'b1111111
  - AN_OFF = 4'b1111
  - hex glyph constants
- One natural sub-module, hex_to_seg: 4-bit value plus valid in, 7-bit active-low segments out, purely combinational.

Test Plan (CLK_DIV=4):
- Reset then no writes → seg=1111111, an=1111 for 4 cycles; then an cycles 0111, 1011, 1101, 1110 every 4 cycles with seg=1111111.
- A writes idx3=4'h1, idx0=4'hF → on LEFT slot seg=1111001 with an=0111; on RIGHT slot seg=0001110 with an=1110; idx2 and idx1 stay blank.
- A and B valid together 3 cycles with prio=A → grants in order A, B, A. Each ready is high only in its granted cycle, and the buffer holds the last grantee's value.
- Write to idx3 in the same cycle as its tick → old glyph shown this slot, new glyph on the next LEFT slot (16 cycles later).
- clr asserted for 1 cycle mid-MIDRIGHT → next edge gives seg=1111111, an=1111, all digits invalid, prio=A.
- With SEG_BLANK_LZ_EN, digits {0,0,0,0} all valid → only an=1110 shows 1000000; with digits {0,2,0,5} → digit 3 blank, digit 1 shows 0.
